// File: rtl/aes_pkg.sv
// Shared encodings for the AES round sequencer: FSM states, key modes and
// the round counts each key mode selects.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUNDS = 2'd1,
        DONE   = 2'd2,
        CLEAR  = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        KM_128     = 2'd0,
        KM_192     = 2'd1,
        KM_256     = 2'd2,
        KM_ILLEGAL = 2'd3
    } key_mode_t;

    localparam int NR_128_DEF = 10;
    localparam int NR_192_DEF = 12;
    localparam int NR_256_DEF = 14;

endpackage

// File: rtl/aes_nr_decode.sv
// Combinational key_mode decode: round count for the selected AES variant
// plus a flag for the reserved encoding.
module aes_nr_decode
    import aes_pkg::*;
#(
    parameter int RND_W  = 4,
    parameter int NR_128 = NR_128_DEF,
    parameter int NR_192 = NR_192_DEF,
    parameter int NR_256 = NR_256_DEF
) (
    input  logic [1:0]       key_mode,
    output logic [RND_W-1:0] nr,
    output logic             illegal
);

    always_comb begin
        nr      = '0;
        illegal = 1'b0;
        case (key_mode_t'(key_mode))
            KM_128:  nr = RND_W'(NR_128);
            KM_192:  nr = RND_W'(NR_192);
            KM_256:  nr = RND_W'(NR_256);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption sequencer: drives an external round function and
// key schedule for 10/12/14 rounds, hands the result over with valid/ack, and
// zeroizes its working registers on completion, abort and debug entry.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int BLOCK_W = 128,
    parameter int NR_128  = NR_128_DEF,
    parameter int NR_192  = NR_192_DEF,
    parameter int NR_256  = NR_256_DEF,
    parameter int RND_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         key_mode,
    input  logic [BLOCK_W-1:0] plaintext,
    input  logic               debug_req,
    output logic               ready,
    output logic               busy,
    output logic [RND_W-1:0]   round_idx,
    input  logic [BLOCK_W-1:0] rk_in,
    output logic [BLOCK_W-1:0] rnd_state,
    output logic               rnd_final,
    input  logic [BLOCK_W-1:0] rnd_result,
    output logic [BLOCK_W-1:0] ciphertext,
    output logic               ciphertext_valid,
    input  logic               ciphertext_ack,
    output logic               err,
    output logic               zeroized
);

    seq_state_t         fsm, fsm_next;
    logic [BLOCK_W-1:0] state_reg, state_next;
    logic [RND_W-1:0]   round_reg, round_next;
    logic [RND_W-1:0]   nr_reg, nr_next;
    logic               err_reg, err_next;

    logic [RND_W-1:0]   nr_dec;
    logic               km_illegal;
    logic               accept;
    logic               last_round;

    aes_nr_decode #(
        .RND_W  (RND_W),
        .NR_128 (NR_128),
        .NR_192 (NR_192),
        .NR_256 (NR_256)
    ) u_nr_decode (
        .key_mode (key_mode),
        .nr       (nr_dec),
        .illegal  (km_illegal)
    );

    assign ready      = (fsm == IDLE) && !debug_req;
    assign busy       = (fsm == ROUNDS) || (fsm == DONE);
    assign accept     = start && ready;
    assign last_round = (round_reg == nr_reg);

    // Working state is only ever visible on the port that owns the phase.
    assign round_idx        = (fsm == ROUNDS) ? round_reg : '0;
    assign rnd_state        = (fsm == ROUNDS) ? state_reg : '0;
    assign rnd_final        = (fsm == ROUNDS) && last_round;
    assign ciphertext_valid = (fsm == DONE);
    assign ciphertext       = (fsm == DONE) ? state_reg : '0;
    assign err              = err_reg;
    assign zeroized         = (fsm == CLEAR);

    always_comb begin
        fsm_next   = fsm;
        state_next = state_reg;
        round_next = round_reg;
        nr_next    = nr_reg;
        err_next   = 1'b0;
        case (fsm)
            IDLE: begin
                if (accept) begin
                    if (km_illegal) begin
                        err_next = 1'b1;
                    end else begin
                        // round_idx is 0 in IDLE, so rk_in is the whitening key
                        state_next = plaintext ^ rk_in;
                        round_next = RND_W'(1);
                        nr_next    = nr_dec;
                        fsm_next   = ROUNDS;
                    end
                end
            end
            ROUNDS: begin
                if (debug_req) begin
                    err_next = 1'b1;
                    fsm_next = CLEAR;
                end else begin
                    state_next = rnd_result;
                    if (last_round) fsm_next = DONE;
                    else            round_next = round_reg + RND_W'(1);
                end
            end
            DONE: begin
                if (debug_req) begin
                    err_next = 1'b1;
                    fsm_next = CLEAR;
                end else if (ciphertext_ack) begin
                    fsm_next = CLEAR;
                end
            end
            CLEAR: begin
                state_next = '0;
                round_next = '0;
                nr_next    = '0;
                fsm_next   = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            state_reg <= '0;
            round_reg <= '0;
            nr_reg    <= '0;
            err_reg   <= 1'b0;
        end else begin
            fsm       <= fsm_next;
            state_reg <= state_next;
            round_reg <= round_next;
            nr_reg    <= nr_next;
            err_reg   <= err_next;
        end
    end

    a_round_in_range: assert property (@(posedge clk) disable iff (rst)
        (fsm == ROUNDS) |-> (round_reg != '0 && round_reg <= nr_reg));

    a_nr_loaded: assert property (@(posedge clk) disable iff (rst)
        (fsm == ROUNDS) |-> (nr_reg != '0));

endmodule
